// File: rtl/main_memory_responder.sv
// Data-memory responder for the core: async-read array with zero-fill after reset,
// plus a first-word-fall-through trace FIFO recording every accepted store.
module main_memory_responder #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned TRACE_DEPTH    = 8,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_WIDTH-1:0]        address_to_main_memory,
  input  logic [DATA_WIDTH-1:0]        data_to_main_memory,
  input  logic                         data_to_main_memory_write_en,
  output logic [DATA_WIDTH-1:0]        data_from_main_memory,
  output logic                         mem_ready,
  output logic                         trace_valid,
  input  logic                         trace_ready,
  output logic [ADDR_WIDTH-1:0]        trace_address,
  output logic [DATA_WIDTH-1:0]        trace_data,
  output logic [$clog2(TRACE_DEPTH):0] trace_count,
  output logic                         trace_overflow
);

  localparam int unsigned PtrW  = $clog2(TRACE_DEPTH);
  localparam int unsigned Words = 2 ** ADDR_WIDTH;
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(TRACE_DEPTH);

  typedef enum logic {StClear, StReady} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clear_ptr_q, clear_ptr_d;

  logic [DATA_WIDTH-1:0] mem       [Words];
  logic [ADDR_WIDTH-1:0] fifo_addr [TRACE_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [TRACE_DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            store, full, push, pop;

  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    case (state_q)
      StClear: begin
        clear_ptr_d = clear_ptr_q + ADDR_WIDTH'(1);
        if (clear_ptr_q == '1) state_d = StReady;
      end
      StReady: state_d = StReady;
    endcase
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    store      = (state_q == StReady) && data_to_main_memory_write_en;
    full       = (count_q == FullCount);
    pop        = (count_q != '0) && trace_ready;
    push       = store && (!full || pop);
    overflow_d = overflow_q | (store && full && !pop);
    wr_ptr_d   = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CLEAR_ON_RESET ? StClear : StReady;
      clear_ptr_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  // Array has no reset of its own so contents survive reset when clearing is disabled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == StClear) begin
        mem[clear_ptr_q] <= '0;
      end else if (data_to_main_memory_write_en) begin
        mem[address_to_main_memory] <= data_to_main_memory;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      fifo_addr[wr_ptr_q] <= address_to_main_memory;
      fifo_data[wr_ptr_q] <= data_to_main_memory;
    end
  end

  always_comb begin
    mem_ready             = (state_q == StReady);
    data_from_main_memory = mem_ready ? mem[address_to_main_memory] : '0;
    trace_valid           = (count_q != '0);
    trace_address         = fifo_addr[rd_ptr_q];
    trace_data            = fifo_data[rd_ptr_q];
    trace_count           = count_q;
    trace_overflow        = overflow_q;
  end

endmodule

// File: tb/tb_main_memory_responder.sv
// Bench for main_memory_responder: directed plan steps then random traffic, all checked
// against a queue/array reference model every cycle.
module tb_main_memory_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [7:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic        we = 1'b0;
  logic        tready = 1'b0;
  logic [15:0] rdata;
  logic        mready, tvalid, tovf;
  logic [7:0]  taddr;
  logic [15:0] tdata;
  logic [3:0]  tcount;

  logic        b_reset = 1'b1;
  logic [7:0]  b_addr = '0;
  logic [15:0] b_wdata = '0;
  logic        b_we = 1'b0;
  logic [15:0] b_rdata;
  logic        b_mready, b_tvalid, b_tovf;
  logic [7:0]  b_taddr;
  logic [15:0] b_tdata;
  logic [3:0]  b_tcount;

  main_memory_responder dut (
    .clk                          (clk),
    .reset                        (reset),
    .address_to_main_memory       (addr),
    .data_to_main_memory          (wdata),
    .data_to_main_memory_write_en (we),
    .data_from_main_memory        (rdata),
    .mem_ready                    (mready),
    .trace_valid                  (tvalid),
    .trace_ready                  (tready),
    .trace_address                (taddr),
    .trace_data                   (tdata),
    .trace_count                  (tcount),
    .trace_overflow               (tovf)
  );

  main_memory_responder #(.CLEAR_ON_RESET(1'b0)) dut_keep (
    .clk                          (clk),
    .reset                        (b_reset),
    .address_to_main_memory       (b_addr),
    .data_to_main_memory          (b_wdata),
    .data_to_main_memory_write_en (b_we),
    .data_from_main_memory        (b_rdata),
    .mem_ready                    (b_mready),
    .trace_valid                  (b_tvalid),
    .trace_ready                  (1'b0),
    .trace_address                (b_taddr),
    .trace_data                   (b_tdata),
    .trace_count                  (b_tcount),
    .trace_overflow               (b_tovf)
  );

  // Reference model
  logic [15:0] ref_mem [256];
  logic [23:0] q [$];
  int          clear_left = 256;
  bit          ref_ovf = 1'b0;
  int          lo_cnt = 0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic rst, input logic [7:0] a, input logic [15:0] d,
                       input logic w, input logic rdy);
    bit exp_ready, popping, was_full;
    @(negedge clk);
    reset = rst; addr = a; wdata = d; we = w; tready = rdy;
    #1;
    exp_ready = (clear_left == 0);
    if (!mready) lo_cnt++;
    chk("mem_ready", 32'(mready), 32'(exp_ready));
    chk("read_data", 32'(rdata), exp_ready ? 32'(ref_mem[a]) : 32'h0);
    chk("trace_count", 32'(tcount), 32'(q.size()));
    chk("trace_valid", 32'(tvalid), 32'(q.size() != 0));
    chk("trace_overflow", 32'(tovf), 32'(ref_ovf));
    if (q.size() != 0) begin
      chk("trace_address", 32'(taddr), 32'(q[0][23:16]));
      chk("trace_data", 32'(tdata), 32'(q[0][15:0]));
    end
    @(posedge clk);
    if (rst) begin
      clear_left = 256;
      q.delete();
      ref_ovf = 1'b0;
      foreach (ref_mem[i]) ref_mem[i] = '0;
    end else if (clear_left != 0) begin
      clear_left--;
    end else begin
      was_full = (q.size() == 8);
      popping  = (q.size() != 0) && rdy;
      if (popping) void'(q.pop_front());
      if (w) begin
        ref_mem[a] = d;
        if (was_full && !popping) ref_ovf = 1'b1;
        else q.push_back({a, d});
      end
    end
  endtask

  task automatic idle(input logic [7:0] a, input logic rdy);
    cycle(1'b0, a, 16'h0, 1'b0, rdy);
  endtask

  initial begin
    foreach (ref_mem[i]) ref_mem[i] = '0;

    // CLEAR_ON_RESET=0 instance: contents survive reset, ready immediately
    repeat (2) @(posedge clk);
    @(negedge clk);
    b_reset = 1'b0; b_we = 1'b1; b_addr = 8'h20; b_wdata = 16'h1234;
    @(negedge clk);
    b_we = 1'b0;
    #1;
    chk("keep_rd_before_rst", 32'(b_rdata), 32'h1234);
    chk("keep_count_before_rst", 32'(b_tcount), 32'd1);
    b_reset = 1'b1;
    @(negedge clk);
    b_reset = 1'b0;
    #1;
    chk("keep_ready_after_rst", 32'(b_mready), 32'd1);
    chk("keep_rd_after_rst", 32'(b_rdata), 32'h1234);
    chk("keep_count_after_rst", 32'(b_tcount), 32'd0);

    // Clear sequence, with a store during CLEAR that must be ignored
    cycle(1'b1, 8'h00, 16'h0, 1'b0, 1'b0);
    lo_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (i == 40) cycle(1'b0, 8'h30, 16'hFFFF, 1'b1, 1'b0);
      else idle(8'hFF, 1'b0);
    end
    chk("clear_len", 32'(lo_cnt), 32'd256);
    idle(8'h00, 1'b0);
    chk("rd_00_cleared", 32'(rdata), 32'h0);
    idle(8'h30, 1'b0);
    chk("rd_30_ignored", 32'(rdata), 32'h0);
    chk("count_after_clear_store", 32'(tcount), 32'd0);
    cycle(1'b0, 8'h05, 16'hBEEF, 1'b1, 1'b0);
    idle(8'h05, 1'b1);
    chk("rd_05", 32'(rdata), 32'hBEEF);

    // Store then read: same-cycle read sees old value
    cycle(1'b0, 8'h10, 16'hA5A5, 1'b1, 1'b0);
    idle(8'h10, 1'b0);
    chk("rd_10_new", 32'(rdata), 32'hA5A5);
    chk("head_addr_10", 32'(taddr), 32'h10);
    chk("count_1", 32'(tcount), 32'd1);
    idle(8'h10, 1'b1);

    // Full FIFO with simultaneous store and pop
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'(8'h40 + i), 16'(16'h1000 + i), 1'b1, 1'b0);
    cycle(1'b0, 8'h50, 16'h4444, 1'b1, 1'b1);
    #1;
    chk("full_pushpop_count", 32'(tcount), 32'd8);
    chk("full_pushpop_ovf", 32'(tovf), 32'd0);
    for (int i = 0; i < 7; i++) idle(8'h00, 1'b1);
    #1;
    chk("last_drained_is_new", 32'(tdata), 32'h4444);
    idle(8'h00, 1'b1);

    // Fill and overflow
    for (int i = 1; i <= 9; i++) cycle(1'b0, 8'(i), 16'(i * 16'h0101), 1'b1, 1'b0);
    #1;
    chk("fill_count", 32'(tcount), 32'd8);
    chk("fill_ovf", 32'(tovf), 32'd1);
    for (int i = 0; i < 8; i++) idle(8'h09, 1'b1);
    #1;
    chk("drained_count", 32'(tcount), 32'd0);
    chk("rd_09", 32'(rdata), 32'h0909);
    idle(8'h00, 1'b1);

    // Reset mid-CLEAR restarts the clear
    cycle(1'b1, 8'h00, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 99; i++) idle(8'h05, 1'b0);
    cycle(1'b1, 8'h00, 16'h0, 1'b0, 1'b0);
    lo_cnt = 0;
    for (int i = 0; i < 260; i++) idle(8'h05, 1'b1);
    chk("restart_clear_len", 32'(lo_cnt), 32'd256);
    chk("restart_fifo_empty", 32'(tcount), 32'd0);

    // Random traffic
    for (int i = 0; i < 700; i++) begin
      cycle(($urandom_range(0, 299) == 0), 8'($urandom_range(0, 15)), 16'($urandom),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
